shift_reg_sequencer: RTL and testbench

Controller that sequences an N-bit universal shift register (select codes 00 hold, 01 shift left, 10 shift right, 11 parallel load). It accepts one word-level request at a time over a valid/ready handshake and executes a transmit frame (load, then N shifts) or a receive frame (N shifts capturing a serial input). It drives the register's select, parallel data, sl_in and sr_in, and reports frame completion. It sits between a word-level client and the shift-register datapath.

---
 rtl/shift_reg_sequencer_pkg.sv | 27 ++
 rtl/shift_seq_counter.sv | 36 +++
 rtl/shift_reg_sequencer.sv | 204 ++++++++++++++++++++
 tb/tb_shift_reg_sequencer.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_reg_sequencer_pkg.sv
// Shared types and constants for the shift-register sequencer.
package shift_reg_sequencer_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StLoad  = 2'b01,
        StShift = 2'b10,
        StGap   = 2'b11
    } seq_state_e;

    // Select codes understood by the universal shift register
    localparam logic [1:0] SEL_HOLD = 2'b00;
    localparam logic [1:0] SEL_SHL  = 2'b01;
    localparam logic [1:0] SEL_SHR  = 2'b10;
    localparam logic [1:0] SEL_LOAD = 2'b11;

    localparam logic MODE_TX   = 1'b0;
    localparam logic MODE_RX   = 1'b1;
    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    // Select code for a shift in the given direction
    function automatic logic [1:0] shift_sel(input logic dir);
        return (dir == DIR_LEFT) ? SEL_SHL : SEL_SHR;
    endfunction

endpackage

// File: rtl/shift_seq_counter.sv
// Clear/increment shift counter with a terminal-count flag at N-1.
module shift_seq_counter #(
    parameter int unsigned N     = 4,
    parameter int unsigned CNT_W = 3
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic inc_i,
    output logic tc_o
);

    logic [CNT_W-1:0] count_d, count_q;

    // Clear wins over increment so a new frame always starts from zero
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (inc_i) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    // Counter state, asynchronously cleared
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tc_o = (count_q == CNT_W'(N - 1));

endmodule

// File: rtl/shift_reg_sequencer.sv
// Word-level sequencer for an N-bit universal shift register.
// Transmit frames load the word then shift N times; receive frames shift N
// times while capturing serial_in into rx_data.
// Optional abort support is compiled in with SHIFT_REG_SEQ_ABORT_EN.
module shift_reg_sequencer #(
    parameter int unsigned N     = 4,
    parameter int unsigned CNT_W = 3,
    parameter int unsigned GAP   = 1
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic         req_mode,
    input  logic         req_dir,
    input  logic [N-1:0] req_data,
    input  logic         serial_in,
    output logic [1:0]   select,
    output logic [N-1:0] par_data,
    output logic         sl_in,
    output logic         sr_in,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] rx_data,
    output logic         rx_valid
`ifdef SHIFT_REG_SEQ_ABORT_EN
    ,
    input  logic         abort,
    output logic         aborted
`endif
);

    import shift_reg_sequencer_pkg::*;

    localparam int unsigned GAP_W = (GAP > 1) ? $clog2(GAP) : 1;

    seq_state_e   state_d, state_q;
    logic         mode_d, mode_q;
    logic         dir_d, dir_q;
    logic [1:0]   select_d, select_q;
    logic [N-1:0] par_data_d, par_data_q;
    logic         done_d, done_q;
    logic         rx_valid_d, rx_valid_q;
    logic [N-1:0] rx_data_d, rx_data_q;
    logic [N-1:0] shadow_d, shadow_q;
    logic [GAP_W-1:0] gap_cnt_d, gap_cnt_q;
    logic         cnt_clear, cnt_inc, cnt_tc;
    logic         gap_last;
    logic         abort_w;

`ifdef SHIFT_REG_SEQ_ABORT_EN
    logic aborted_d, aborted_q;
    assign abort_w = abort;
    assign aborted = aborted_q;
`else
    assign abort_w = 1'b0;
`endif

    shift_seq_counter #(
        .N     (N),
        .CNT_W (CNT_W)
    ) u_counter (
        .clk_i   (clock),
        .rst_i   (reset),
        .clear_i (cnt_clear),
        .inc_i   (cnt_inc),
        .tc_o    (cnt_tc)
    );

    assign gap_last = (32'(gap_cnt_q) == GAP - 1);

    // Next-state and next-output decode; outputs are registered from these
    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        dir_d      = dir_q;
        select_d   = SEL_HOLD;
        par_data_d = par_data_q;
        done_d     = 1'b0;
        rx_valid_d = 1'b0;
        rx_data_d  = rx_data_q;
        shadow_d   = shadow_q;
        gap_cnt_d  = gap_cnt_q;
        cnt_clear  = 1'b0;
        cnt_inc    = 1'b0;
`ifdef SHIFT_REG_SEQ_ABORT_EN
        aborted_d  = 1'b0;
`endif

        unique case (state_q)
            StIdle: begin
                // A same-cycle abort suppresses the accept
                if (req_valid && !abort_w) begin
                    mode_d    = req_mode;
                    dir_d     = req_dir;
                    cnt_clear = 1'b1;
                    if (req_mode == MODE_TX) begin
                        par_data_d = req_data;
                        state_d    = StLoad;
                    end else begin
                        state_d = StShift;
                    end
                end
            end
            StLoad: begin
                state_d = StShift;
            end
            StShift: begin
                cnt_inc  = 1'b1;
                shadow_d = (dir_q == DIR_LEFT) ? {shadow_q[N-2:0], serial_in}
                                               : {serial_in, shadow_q[N-1:1]};
                if (cnt_tc) begin
                    done_d = 1'b1;
                    if (mode_q == MODE_RX) begin
                        rx_valid_d = 1'b1;
                        rx_data_d  = shadow_d;
                    end
                    if (GAP > 0) begin
                        state_d   = StGap;
                        gap_cnt_d = '0;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            StGap: begin
                if (gap_last) begin
                    state_d = StIdle;
                end else begin
                    gap_cnt_d = gap_cnt_q + GAP_W'(1);
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Abort drops the frame without reporting completion
        if (abort_w && (state_q != StIdle)) begin
            state_d    = StIdle;
            done_d     = 1'b0;
            rx_valid_d = 1'b0;
            rx_data_d  = rx_data_q;
`ifdef SHIFT_REG_SEQ_ABORT_EN
            aborted_d  = 1'b1;
`endif
        end

        // Select is registered, so it is derived from the state being entered
        if (state_d == StLoad) begin
            select_d = SEL_LOAD;
        end else if (state_d == StShift) begin
            select_d = shift_sel(dir_d);
        end
    end

    // FSM and registered outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            mode_q     <= MODE_TX;
            dir_q      <= DIR_LEFT;
            select_q   <= SEL_HOLD;
            par_data_q <= '0;
            done_q     <= 1'b0;
            rx_valid_q <= 1'b0;
            rx_data_q  <= '0;
            shadow_q   <= '0;
            gap_cnt_q  <= '0;
`ifdef SHIFT_REG_SEQ_ABORT_EN
            aborted_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            dir_q      <= dir_d;
            select_q   <= select_d;
            par_data_q <= par_data_d;
            done_q     <= done_d;
            rx_valid_q <= rx_valid_d;
            rx_data_q  <= rx_data_d;
            shadow_q   <= shadow_d;
            gap_cnt_q  <= gap_cnt_d;
`ifdef SHIFT_REG_SEQ_ABORT_EN
            aborted_q  <= aborted_d;
`endif
        end
    end

    assign req_ready = (state_q == StIdle);
    assign busy      = (state_q != StIdle);
    assign select    = select_q;
    assign par_data  = par_data_q;
    assign done      = done_q;
    assign rx_valid  = rx_valid_q;
    assign rx_data   = rx_data_q;

    // Receive fill bits pass serial_in straight through to the shifting end
    assign sl_in = (state_q == StShift && mode_q == MODE_RX && dir_q == DIR_LEFT)
                   ? serial_in : 1'b0;
    assign sr_in = (state_q == StShift && mode_q == MODE_RX && dir_q == DIR_RIGHT)
                   ? serial_in : 1'b0;

endmodule

// File: tb/tb_shift_reg_sequencer.sv
// Bench for shift_reg_sequencer: two instances (GAP=1 and GAP=0) share stimulus;
// one at a time is compared per cycle against a frame-level expectation queue.
module tb_shift_reg_sequencer;

    localparam int N = 4;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic         req_valid = 1'b0;
    logic         req_mode = 1'b0;
    logic         req_dir = 1'b0;
    logic [N-1:0] req_data = '0;
    logic         serial_in = 1'b0;
    logic         abort = 1'b0;

    logic [1:0]   sel0, sel1, o_sel;
    logic [N-1:0] par0, par1, o_par;
    logic [N-1:0] rxd0, rxd1, o_rxd;
    logic         rdy0, rdy1, o_rdy;
    logic         sl0, sl1, o_sl;
    logic         sr0, sr1, o_sr;
    logic         bsy0, bsy1, o_bsy;
    logic         dn0, dn1, o_dn;
    logic         rxv0, rxv1, o_rxv;
`ifdef SHIFT_REG_SEQ_ABORT_EN
    logic         ab0, ab1, o_ab;
`endif

    bit dut_sel = 1'b0;
    int gap_cur = 1;

    always #5 clock = ~clock;

    shift_reg_sequencer #(.N(N), .CNT_W(3), .GAP(1)) dut0 (
        .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(rdy0),
        .req_mode(req_mode), .req_dir(req_dir), .req_data(req_data),
        .serial_in(serial_in), .select(sel0), .par_data(par0), .sl_in(sl0),
        .sr_in(sr0), .busy(bsy0), .done(dn0), .rx_data(rxd0), .rx_valid(rxv0)
`ifdef SHIFT_REG_SEQ_ABORT_EN
        , .abort(abort), .aborted(ab0)
`endif
    );

    shift_reg_sequencer #(.N(N), .CNT_W(3), .GAP(0)) dut1 (
        .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(rdy1),
        .req_mode(req_mode), .req_dir(req_dir), .req_data(req_data),
        .serial_in(serial_in), .select(sel1), .par_data(par1), .sl_in(sl1),
        .sr_in(sr1), .busy(bsy1), .done(dn1), .rx_data(rxd1), .rx_valid(rxv1)
`ifdef SHIFT_REG_SEQ_ABORT_EN
        , .abort(abort), .aborted(ab1)
`endif
    );

    always_comb begin
        if (dut_sel) begin
            o_sel = sel1; o_par = par1; o_rxd = rxd1; o_rdy = rdy1; o_sl = sl1;
            o_sr = sr1; o_bsy = bsy1; o_dn = dn1; o_rxv = rxv1;
        end else begin
            o_sel = sel0; o_par = par0; o_rxd = rxd0; o_rdy = rdy0; o_sl = sl0;
            o_sr = sr0; o_bsy = bsy0; o_dn = dn0; o_rxv = rxv0;
        end
`ifdef SHIFT_REG_SEQ_ABORT_EN
        o_ab = dut_sel ? ab1 : ab0;
`endif
    end

    // One expected cycle of DUT behaviour
    typedef struct packed {
        logic [1:0]   sel;
        logic         busy;
        logic         ready;
        logic         done;
        logic         rxv;
        logic         aborted;
        logic         load;
        logic         rxshift;
        logic         dir;
        logic [N-1:0] word;
    } rec_t;

    rec_t         exp_q[$];
    rec_t         cur, prev_rec;
    logic         bits_q[$];
    logic [N-1:0] par_exp, rx_exp;
    logic         prev_valid, prev_mode, prev_dir, prev_abort;
    logic [N-1:0] prev_data;
    bit           acc_flag;
    int           n_total = 0;
    int           n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic rec_t idle_rec();
        rec_t r;
        r = '0;
        r.ready = 1'b1;
        return r;
    endfunction

    function automatic rec_t busy_rec();
        rec_t r;
        r = '0;
        r.busy = 1'b1;
        return r;
    endfunction

    // Expected trace of a whole frame, from the latency rules
    task automatic push_frame(input logic m, input logic d, input logic [N-1:0] w);
        rec_t r;
        if (m == 1'b0) begin
            r = busy_rec(); r.sel = 2'b11; r.load = 1'b1; r.word = w;
            exp_q.push_back(r);
        end
        for (int i = 0; i < N; i++) begin
            r = busy_rec(); r.sel = d ? 2'b10 : 2'b01; r.rxshift = m; r.dir = d;
            exp_q.push_back(r);
        end
        if (gap_cur > 0) begin
            for (int g = 0; g < gap_cur; g++) begin
                r = busy_rec();
                if (g == 0) begin r.done = 1'b1; r.rxv = m; r.dir = d; end
                exp_q.push_back(r);
            end
        end else begin
            r = idle_rec(); r.done = 1'b1; r.rxv = m; r.dir = d;
            exp_q.push_back(r);
        end
    endtask

    // Apply what happened at the edge just passed, then pick this cycle's expectation
    task automatic advance();
        acc_flag = 1'b0;
        if (prev_abort && prev_rec.busy) begin
            exp_q.delete();
            bits_q.delete();
            cur = idle_rec();
            cur.aborted = 1'b1;
        end else begin
            if (prev_rec.ready && prev_valid && !prev_abort) begin
                acc_flag = 1'b1;
                push_frame(prev_mode, prev_dir, prev_data);
            end
            cur = (exp_q.size() > 0) ? exp_q.pop_front() : idle_rec();
        end
    endtask

    // Compare one cycle at the falling edge, then move past the next rising edge
    task automatic cycle();
        logic exp_sl, exp_sr;
        @(negedge clock);
        if (cur.load) par_exp = cur.word;
        if (cur.rxshift) bits_q.push_back(serial_in);
        if (cur.rxv) begin
            rx_exp = '0;
            foreach (bits_q[i]) begin
                if (cur.dir) rx_exp[i] = bits_q[i];
                else rx_exp[N-1-i] = bits_q[i];
            end
            bits_q.delete();
        end
        exp_sl = (cur.rxshift && !cur.dir) ? serial_in : 1'b0;
        exp_sr = (cur.rxshift && cur.dir) ? serial_in : 1'b0;
        check_eq("select", 32'(o_sel), 32'(cur.sel));
        check_eq("busy", 32'(o_bsy), 32'(cur.busy));
        check_eq("req_ready", 32'(o_rdy), 32'(cur.ready));
        check_eq("done", 32'(o_dn), 32'(cur.done));
        check_eq("rx_valid", 32'(o_rxv), 32'(cur.rxv));
        check_eq("rx_data", 32'(o_rxd), 32'(rx_exp));
        check_eq("par_data", 32'(o_par), 32'(par_exp));
        check_eq("sl_in", 32'(o_sl), 32'(exp_sl));
        check_eq("sr_in", 32'(o_sr), 32'(exp_sr));
`ifdef SHIFT_REG_SEQ_ABORT_EN
        check_eq("aborted", 32'(o_ab), 32'(cur.aborted));
`endif
        prev_rec   = cur;
        prev_valid = req_valid;
        prev_mode  = req_mode;
        prev_dir   = req_dir;
        prev_data  = req_data;
        prev_abort = abort;
        @(posedge clock);
        #1;
        advance();
    endtask

    // Asynchronous reset; outputs must clear without waiting for a clock
    task automatic do_reset();
        reset = 1'b1;
        req_valid = 1'b0;
        abort = 1'b0;
        #1;
        check_eq("rst_select", 32'(o_sel), 32'd0);
        check_eq("rst_busy", 32'(o_bsy), 32'd0);
        check_eq("rst_done", 32'(o_dn), 32'd0);
        check_eq("rst_rx_valid", 32'(o_rxv), 32'd0);
        check_eq("rst_rx_data", 32'(o_rxd), 32'd0);
        check_eq("rst_par_data", 32'(o_par), 32'd0);
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        exp_q.delete();
        bits_q.delete();
        par_exp = '0;
        rx_exp = '0;
        cur = idle_rec();
        prev_rec = '0;
        prev_valid = 1'b0;
        prev_abort = 1'b0;
        acc_flag = 1'b0;
    endtask

    task automatic wait_accept(input string tag);
        int k;
        k = 0;
        do begin
            cycle();
            k++;
        end while (!acc_flag && k < 40);
        check_eq({tag, "_bound"}, 32'(k < 40), 32'd1);
        check_eq({tag, "_busy"}, 32'(o_bsy), 32'd1);
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while ((cur.busy || exp_q.size() != 0) && k < 60) begin
            cycle();
            k++;
        end
        check_eq("idle_bound", 32'(k < 60), 32'd1);
        cycle();
    endtask

    task automatic new_req();
        req_valid = 1'b1;
        req_mode  = 1'($urandom);
        req_dir   = 1'($urandom);
        req_data  = N'($urandom);
    endtask

    task automatic rand_run(input int cycles);
        for (int c = 0; c < cycles; c++) begin
            cycle();
            if (acc_flag) begin
                if ($urandom_range(1, 0) == 1) new_req();
                else req_valid = 1'b0;
            end else if (!req_valid && $urandom_range(3, 0) == 0) begin
                new_req();
            end else if (req_valid && $urandom_range(1, 0) == 1) begin
                req_data = N'($urandom);
            end
            serial_in = 1'($urandom);
`ifdef SHIFT_REG_SEQ_ABORT_EN
            abort = ($urandom_range(19, 0) == 0);
`endif
        end
        req_valid = 1'b0;
        abort = 1'b0;
        wait_idle();
    endtask

    initial begin
        logic [N-1:0] seq;
        #2;
        dut_sel = 1'b0;
        gap_cur = 1;
        do_reset();

        // Transmit 1011, shift left, GAP=1
        req_valid = 1'b1; req_mode = 1'b0; req_dir = 1'b0; req_data = 4'b1011;
        wait_accept("tx_acc");
        req_valid = 1'b0;
        check_eq("tx_load_sel", 32'(o_sel), 32'h3);
        check_eq("tx_load_par", 32'(o_par), 32'hb);
        repeat (N + 1) cycle();
        check_eq("tx_done", 32'(o_dn), 32'd1);
        check_eq("tx_gap_sel", 32'(o_sel), 32'd0);
        cycle();
        check_eq("tx_ready_after", 32'(o_rdy), 32'd1);
        wait_idle();

        // Receive, shift right, serial 1,0,0,1
        seq = 4'b1001;
        req_valid = 1'b1; req_mode = 1'b1; req_dir = 1'b1; req_data = N'($urandom);
        wait_accept("rx_acc");
        req_valid = 1'b0;
        for (int i = 0; i < N; i++) begin
            serial_in = seq[N-1-i];
            cycle();
        end
        #1;
        check_eq("rx_word", 32'(o_rxd), 32'h9);
        check_eq("rx_valid_pulse", 32'(o_rxv), 32'd1);
        wait_idle();

        // Reset after two shifts of a receive frame, then a full frame from count 0
        req_valid = 1'b1; req_mode = 1'b1; req_dir = 1'b0; req_data = '0;
        wait_accept("mid_acc");
        req_valid = 1'b0;
        cycle();
        cycle();
        do_reset();
        req_valid = 1'b1; req_mode = 1'b0; req_dir = 1'b1; req_data = 4'b0110;
        wait_accept("post_rst_acc");
        req_valid = 1'b0;
        wait_idle();

        rand_run(300);

        // GAP=0 instance: held request with changing data, back-to-back frames
        dut_sel = 1'b1;
        gap_cur = 0;
        do_reset();
        req_valid = 1'b1; req_mode = 1'b0; req_dir = 1'b1; req_data = 4'b0110;
        wait_accept("b2b_acc1");
        check_eq("b2b_par1", 32'(o_par), 32'h6);
        req_mode = 1'b0;
        do begin
            req_data = N'($urandom);
            cycle();
        end while (!acc_flag && cur.busy);
        if (!acc_flag) cycle();
        check_eq("b2b_load_sel", 32'(o_sel), 32'h3);
        check_eq("b2b_busy", 32'(o_bsy), 32'd1);
        req_valid = 1'b0;
        wait_idle();

`ifdef SHIFT_REG_SEQ_ABORT_EN
        // Abort in the second SHIFT cycle of a receive frame
        req_valid = 1'b1; req_mode = 1'b1; req_dir = 1'b0; req_data = '0;
        wait_accept("ab_acc");
        req_valid = 1'b0;
        cycle();
        abort = 1'b1;
        cycle();
        abort = 1'b0;
        #1;
        check_eq("ab_pulse", 32'(o_ab), 32'd1);
        check_eq("ab_no_done", 32'(o_dn), 32'd0);
        check_eq("ab_rx_hold", 32'(o_rxd), 32'(rx_exp));
        // Abort in IDLE blocks a same-cycle accept
        req_valid = 1'b1;
        abort = 1'b1;
        cycle();
        abort = 1'b0;
        req_valid = 1'b0;
        #1;
        check_eq("ab_idle_no_acc", 32'(o_bsy), 32'd0);
        wait_idle();
`endif

        rand_run(300);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
